// File: rtl/mux_2x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_2x1_rr_arbiter
// Brief    : Round-robin grant FSM driving a shared 2:1 data mux between two
//            valid/ready requesters; counts accepted downstream transfers.
//            Optional packet lock: define MUX_ARB_PKT_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux_2x1_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_valid0,
    input  logic [WIDTH-1:0] in_data0,
`ifdef MUX_ARB_PKT_LOCK_EN
    input  logic             in_last0,
`endif
    output logic             out_ready0,
    input  logic             in_valid1,
    input  logic [WIDTH-1:0] in_data1,
`ifdef MUX_ARB_PKT_LOCK_EN
    input  logic             in_last1,
`endif
    output logic             out_ready1,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             in_ready,
    output logic             out_sel,
    output logic             out_busy,
    output logic [CNT_W-1:0] out_xfer_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL0 = 2'd1,
        ST_SEL1 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ptr;
    logic             w_ptr_nxt;
    logic             r_sel;
    logic [CNT_W-1:0] r_xfer_cnt;

    logic             w_is_sel1;
    logic             w_own_valid;
    logic             w_oth_valid;
    logic             w_own_last;
    logic             w_in_pkt;
    logic             w_xfer;
    state_t           w_own_st;
    state_t           w_oth_st;

    // Everything below is phrased relative to the currently granted side.
    assign w_is_sel1   = (r_state == ST_SEL1);
    assign w_own_valid = w_is_sel1 ? in_valid1 : in_valid0;
    assign w_oth_valid = w_is_sel1 ? in_valid0 : in_valid1;
    assign w_own_st    = w_is_sel1 ? ST_SEL1 : ST_SEL0;
    assign w_oth_st    = w_is_sel1 ? ST_SEL0 : ST_SEL1;

`ifdef MUX_ARB_PKT_LOCK_EN
    logic r_in_pkt;

    assign w_own_last = w_is_sel1 ? in_last1 : in_last0;
    assign w_in_pkt   = r_in_pkt;

    // Set once a non-last beat is accepted; keeps the grant across withdrawn valids.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_in_pkt <= 1'b0;
        end else if (w_xfer) begin
            r_in_pkt <= ~w_own_last;
        end
    end
`else
    assign w_own_last = 1'b1;
    assign w_in_pkt   = 1'b0;
`endif

    assign out_valid  = ((r_state == ST_SEL0) & in_valid0) | ((r_state == ST_SEL1) & in_valid1);
    assign out_ready0 = (r_state == ST_SEL0) & in_ready;
    assign out_ready1 = (r_state == ST_SEL1) & in_ready;
    assign w_xfer     = out_valid & in_ready;
    assign out_data   = r_sel ? in_data1 : in_data0;
    assign out_sel    = r_sel;
    assign out_busy   = (r_state != ST_IDLE);
    assign out_xfer_cnt = r_xfer_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (in_valid0 && in_valid1) begin
                    w_state_nxt = r_ptr ? ST_SEL1 : ST_SEL0;
                end else if (in_valid0) begin
                    w_state_nxt = ST_SEL0;
                end else if (in_valid1) begin
                    w_state_nxt = ST_SEL1;
                end
            end
            ST_SEL0, ST_SEL1: begin
                if (w_xfer) begin
                    if (w_own_last) begin
                        w_ptr_nxt = ~w_is_sel1;
                        // A transfer implies own valid, so the IDLE fallback cannot occur here.
                        if (w_oth_valid) begin
                            w_state_nxt = w_oth_st;
                        end else begin
                            w_state_nxt = w_own_st;
                        end
                    end
                end else if (!w_own_valid && !w_in_pkt) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 1'b0;
            r_sel      <= 1'b0;
            r_xfer_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= (w_state_nxt == ST_SEL1);
            if (w_xfer) begin
                r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_2x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_2x1_rr_arbiter
// Brief    : Vector table plus data scoreboard for mux_2x1_rr_arbiter; a
//            second instance with a 4-bit counter covers wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_2x1_rr_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             v0, v1, rdy;
    logic             last0, last1;
    logic [WIDTH-1:0] d0, d1;

    logic             r0, r1, o_valid, o_sel, o_busy;
    logic [WIDTH-1:0] o_data;
    logic [15:0]      o_cnt;

    logic             r0_w, r1_w, o_valid_w, o_sel_w, o_busy_w;
    logic [WIDTH-1:0] o_data_w;
    logic [3:0]       o_cnt_w;

    always #5 clk = ~clk;

    mux_2x1_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .in_clk(clk), .in_rst(rst),
        .in_valid0(v0), .in_data0(d0),
`ifdef MUX_ARB_PKT_LOCK_EN
        .in_last0(last0),
`endif
        .out_ready0(r0),
        .in_valid1(v1), .in_data1(d1),
`ifdef MUX_ARB_PKT_LOCK_EN
        .in_last1(last1),
`endif
        .out_ready1(r1),
        .out_valid(o_valid), .out_data(o_data), .in_ready(rdy),
        .out_sel(o_sel), .out_busy(o_busy), .out_xfer_cnt(o_cnt)
    );

    mux_2x1_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(4)) dut_w (
        .in_clk(clk), .in_rst(rst),
        .in_valid0(v0), .in_data0(d0),
`ifdef MUX_ARB_PKT_LOCK_EN
        .in_last0(last0),
`endif
        .out_ready0(r0_w),
        .in_valid1(v1), .in_data1(d1),
`ifdef MUX_ARB_PKT_LOCK_EN
        .in_last1(last1),
`endif
        .out_ready1(r1_w),
        .out_valid(o_valid_w), .out_data(o_data_w), .in_ready(rdy),
        .out_sel(o_sel_w), .out_busy(o_busy_w), .out_xfer_cnt(o_cnt_w)
    );

    typedef struct {
        logic        rst;
        logic        v0;
        logic [7:0]  d0;
        logic        v1;
        logic [7:0]  d1;
        logic        rdy;
        logic        e_valid;
        logic        e_sel;
        logic [7:0]  e_data;
        logic        e_r0;
        logic        e_r1;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb_q[$];
    int         pass_cnt  = 0;
    int         total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic r, input logic a_v0, input logic [7:0] a_d0,
                       input logic a_v1, input logic [7:0] a_d1, input logic a_rdy,
                       input logic ev, input logic es, input logic [7:0] ed,
                       input logic er0, input logic er1, input logic eb, input logic [15:0] ec);
        vec_t t;
        t.rst = r;  t.v0 = a_v0; t.d0 = a_d0; t.v1 = a_v1; t.d1 = a_d1; t.rdy = a_rdy;
        t.e_valid = ev; t.e_sel = es; t.e_data = ed; t.e_r0 = er0; t.e_r1 = er1;
        t.e_busy = eb; t.e_cnt = ec;
        vecs.push_back(t);
    endtask

    initial begin
        //  rst v0 d0     v1 d1     rdy | valid sel data   r0 r1 busy cnt
        add(0, 1, 8'hA0, 1, 8'hB0, 1,    0, 0, 8'hA0, 0, 0, 0, 16'd0);   // idle, arbitrate
        add(0, 1, 8'hA0, 1, 8'hB0, 1,    1, 0, 8'hA0, 1, 0, 1, 16'd0);   // first grant -> req0
        add(0, 1, 8'hA1, 1, 8'hB0, 1,    1, 1, 8'hB0, 0, 1, 1, 16'd1);
        add(0, 1, 8'hA1, 1, 8'hB1, 1,    1, 0, 8'hA1, 1, 0, 1, 16'd2);
        add(0, 1, 8'hA2, 1, 8'hB1, 1,    1, 1, 8'hB1, 0, 1, 1, 16'd3);
        add(0, 0, 8'hA2, 1, 8'hC5, 1,    0, 0, 8'hA2, 1, 0, 1, 16'd4);   // req0 withdraws
        add(0, 0, 8'hA2, 1, 8'hC5, 0,    0, 0, 8'hA2, 0, 0, 0, 16'd4);
        add(0, 1, 8'hA3, 1, 8'hC5, 0,    1, 1, 8'hC5, 0, 0, 1, 16'd4);   // backpressure x3
        add(0, 1, 8'hA3, 1, 8'hC5, 0,    1, 1, 8'hC5, 0, 0, 1, 16'd4);
        add(0, 1, 8'hA3, 1, 8'hC5, 0,    1, 1, 8'hC5, 0, 0, 1, 16'd4);
        add(0, 1, 8'hA3, 1, 8'hC5, 1,    1, 1, 8'hC5, 0, 1, 1, 16'd4);
        add(0, 1, 8'hA3, 0, 8'h00, 1,    1, 0, 8'hA3, 1, 0, 1, 16'd5);   // single requester
        add(0, 1, 8'hA4, 0, 8'h00, 1,    1, 0, 8'hA4, 1, 0, 1, 16'd6);
        add(0, 1, 8'hA5, 0, 8'h00, 1,    1, 0, 8'hA5, 1, 0, 1, 16'd7);
        add(0, 1, 8'hA6, 0, 8'h00, 1,    1, 0, 8'hA6, 1, 0, 1, 16'd8);
        add(0, 1, 8'hA7, 0, 8'h00, 1,    1, 0, 8'hA7, 1, 0, 1, 16'd9);
        add(0, 0, 8'hA7, 0, 8'h00, 1,    0, 0, 8'hA7, 1, 0, 1, 16'd10);
        add(0, 0, 8'hA7, 0, 8'h00, 1,    0, 0, 8'hA7, 0, 0, 0, 16'd10);
        add(0, 1, 8'hA8, 1, 8'hB8, 0,    0, 0, 8'hA8, 0, 0, 0, 16'd10);  // pointer now 1
        add(0, 1, 8'hA8, 1, 8'hB8, 0,    1, 1, 8'hB8, 0, 0, 1, 16'd10);
        add(0, 1, 8'hA8, 1, 8'hB8, 1,    1, 1, 8'hB8, 0, 1, 1, 16'd10);
        add(0, 1, 8'hA8, 0, 8'hB8, 1,    1, 0, 8'hA8, 1, 0, 1, 16'd11);
        add(0, 0, 8'hA8, 0, 8'hB8, 1,    0, 0, 8'hA8, 1, 0, 1, 16'd12);
        add(0, 0, 8'hA8, 0, 8'hB8, 1,    0, 0, 8'hA8, 0, 0, 0, 16'd12);
        add(0, 1, 8'hA9, 0, 8'h00, 1,    0, 0, 8'hA9, 0, 0, 0, 16'd12);
        add(1, 1, 8'hA9, 0, 8'h00, 1,    1, 0, 8'hA9, 1, 0, 1, 16'd12);  // reset mid-beat
        add(0, 0, 8'hA9, 0, 8'h00, 1,    0, 0, 8'hA9, 0, 0, 0, 16'd0);

        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; rdy = 1'b1;
        d0 = 8'h00; d1 = 8'h00; last0 = 1'b1; last1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_sel",   32'(o_sel),   32'd0);
        check("rst_cnt",   32'(o_cnt),   32'd0);
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_cnt_w", 32'(o_cnt_w), 32'd0);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            rst = vecs[i].rst; v0 = vecs[i].v0; d0 = vecs[i].d0;
            v1 = vecs[i].v1; d1 = vecs[i].d1; rdy = vecs[i].rdy;
            if (vecs[i].e_valid && vecs[i].rdy) sb_q.push_back(vecs[i].e_data);
            @(negedge clk);
            check($sformatf("row%0d_valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
            check($sformatf("row%0d_sel",   i), 32'(o_sel),   32'(vecs[i].e_sel));
            check($sformatf("row%0d_data",  i), 32'(o_data),  32'(vecs[i].e_data));
            check($sformatf("row%0d_rdy0",  i), 32'(r0),      32'(vecs[i].e_r0));
            check($sformatf("row%0d_rdy1",  i), 32'(r1),      32'(vecs[i].e_r1));
            check($sformatf("row%0d_busy",  i), 32'(o_busy),  32'(vecs[i].e_busy));
            check($sformatf("row%0d_cnt",   i), 32'(o_cnt),   32'(vecs[i].e_cnt));
            check($sformatf("row%0d_cnt_w", i), 32'(o_cnt_w), 32'(vecs[i].e_cnt[3:0]));
            if (o_valid && rdy) begin
                if (sb_q.size() == 0) check($sformatf("row%0d_sb_unexpected", i), 32'd1, 32'd0);
                else check($sformatf("row%0d_sb_data", i), 32'(o_data), 32'(sb_q.pop_front()));
            end
        end
        check("sb_leftover", 32'(sb_q.size()), 32'd0);

`ifdef MUX_ARB_PKT_LOCK_EN
        @(posedge clk); #1;
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 8'h50; d1 = 8'h60; last0 = 1'b0; rdy = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
            d0 = 8'h50 + 8'(b);
            last0 = (b == 2);
            @(negedge clk);
            check($sformatf("pkt_beat%0d_sel", b),  32'(o_sel),   32'd0);
            check($sformatf("pkt_beat%0d_data", b), 32'(o_data),  32'(8'h50 + 8'(b)));
            check($sformatf("pkt_beat%0d_valid", b), 32'(o_valid), 32'd1);
        end
        @(posedge clk); #1;
        last0 = 1'b1;
        @(negedge clk);
        check("pkt_after_sel",  32'(o_sel),  32'd1);
        check("pkt_after_data", 32'(o_data), 32'h60);
`endif

        // 17 transfers: 16-bit counter reads 17, 4-bit counter wraps to 1.
        @(posedge clk); #1;
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rdy = 1'b1; last0 = 1'b1; last1 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; v0 = 1'b1; d0 = 8'h11;
        repeat (18) @(posedge clk);
        #1;
        v0 = 1'b0;
        @(negedge clk);
        check("wrap_cnt4",  32'(o_cnt_w), 32'd1);
        check("wrap_cnt16", 32'(o_cnt),   32'd17);
        check("wrap_sel",   32'(o_sel),   32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_2x1_rr_arbiter.md
Name: mux_2x1_rr_arbiter

Overview:
Round-robin arbiter that shares one 2:1 data mux between two valid/ready requesters and drives the mux select from a small grant state machine. The granted requester's beat is forwarded to a single downstream valid/ready port. It sits in front of a shared downstream consumer and provides fair one-beat-per-grant alternation, plus a transfer counter for bring-up visibility.

Parameters:
WIDTH, 8, data width of each requester and of the output
CNT_W, 16, width of the accepted-transfer counter

Ports:
in_clk  input  1  clock; all logic is on the rising edge
in_rst  input  1  synchronous, active-high reset
in_valid0  input  1  requester 0 has a beat
in_data0  input  WIDTH  requester 0 data
out_ready0  output  1  requester 0 beat accepted this cycle
in_valid1  input  1  requester 1 has a beat
in_data1  input  WIDTH  requester 1 data
out_ready1  output  1  requester 1 beat accepted this cycle
out_valid  output  1  forwarded beat valid
out_data  output  WIDTH  forwarded data; mux of in_data0/in_data1 by out_sel
in_ready  input  1  downstream ready
out_sel  output  1  current mux select (0 = requester 0, 1 = requester 1)
out_busy  output  1  high when state is not IDLE
out_xfer_cnt  output  CNT_W  count of accepted downstream transfers

Behaviour:
- One clock (in_clk). Reset is synchronous and active-high on in_rst.
- Reset values: state = IDLE, priority pointer = 0, out_sel = 0, out_xfer_cnt = 0, out_busy = 0. out_valid, out_ready0 and out_ready1 are all 0 because the state is IDLE.
- States: IDLE, SEL0, SEL1. out_sel is registered: 0 in IDLE and SEL0, 1 in SEL1.
- out_data is a combinational 2:1 mux of in_data0/in_data1 selected by out_sel.
- out_valid = (SEL0 & in_valid0) | (SEL1 & in_valid1).
- out_ready0 = SEL0 & in_ready. out_ready1 = SEL1 & in_ready. Requester ready never depends on the requester's own valid.
- Transfer = out_valid & in_ready.
- IDLE:
  - No valid: stay in IDLE.
  - Only one valid: go to that requester's SEL state.
  - Both valid: go to the SEL state named by the pointer.
  - Arbitration latency is 1 cycle from valid to out_valid.
- SELx with a transfer:
  - Pointer becomes the other requester.
  - Next state: SEL(other) if the other requester is valid this cycle; else SELx if requester x is valid; else IDLE.
  - Result: back-to-back beats with no bubble, and strict alternation while both requesters are valid.
- SELx with valid high but no ready: hold state and hold out_sel. The requester must hold its valid and data stable.
- SELx with requester x valid low (request withdrawn): go to IDLE, with no transfer and no pointer change.
- out_xfer_cnt increments by 1 on each transfer and wraps from 2^CNT_W-1 to 0.
- Reset mid-transfer: at the next edge go to IDLE, pointer 0, counter 0. The beat in flight is not counted.
- out_sel changes only at clock edges, so there is no glitching on the select.

Optional Feature:
- Macro: MUX_ARB_PKT_LOCK_EN.
- Defined:
  - Adds input ports in_last0 and in_last1 (1 bit each).
  - In SELx, a transfer with in_lastx = 0 keeps state SELx regardless of the other requester and leaves the pointer unchanged.
  - Only a transfer with in_lastx = 1 applies the normal SELx transition rules.
  - A withdrawn valid mid-packet still holds SELx; IDLE is reached only after last or on reset.
- Undefined: the ports do not exist and every beat is re-arbitrated as specified above.

Test Plan:
- Reset: hold in_rst high for 2 cycles with both valids high -> out_valid = 0, out_sel = 0, out_xfer_cnt = 0. The first grant after release goes to requester 0.
- Alternation: both valids held high, in_ready = 1, data0 = 0xA0..., data1 = 0xB0... -> after 1 cycle latency, out_data alternates A0, B0, A1, B1 with one beat per cycle and out_xfer_cnt = 4 after 4 beats.
- Backpressure: grant to requester 1, in_ready = 0 for 3 cycles -> out_sel stays 1, out_data stays at in_data1, out_ready1 = 0; the transfer occurs in the cycle in_ready rises.
- Single requester: only in_valid0 is high for 5 beats with in_ready = 1 -> out_sel stays 0, there are no bubbles, and the state returns to IDLE after the valid drops.
- Counter wrap, with CNT_W = 4: run 17 transfers -> out_xfer_cnt reads 1.
- Packet lock (macro defined): requester 0 sends a 3-beat packet (last on beat 3) while requester 1 is valid -> three requester-0 beats, then requester 1 is granted.
